// File: rtl/regfile_writeback_arbiter_if.sv
// Write-back arbiter bus bundle.
// Groups the main-pipeline write request, the long-latency result handshake,
// the issue/scoreboard signals and the registered register-file write port.
//   master : producer side (pipeline, long-latency unit, decode issue) and
//            consumer of lu_ready, busy and the register-file write port
//   slave  : the arbiter itself
interface regfile_writeback_arbiter_if #(
  parameter int AW = 5,
  parameter int DW = 32
);
  logic          pipe_we;
  logic [AW-1:0] pipe_addr;
  logic [DW-1:0] pipe_data;
  logic          lu_valid;
  logic [AW-1:0] lu_addr;
  logic [DW-1:0] lu_data;
  logic          lu_ready;
  logic          issue_en;
  logic [AW-1:0] issue_addr;
  logic [31:0]   busy;
  logic          WriteEn;
  logic [AW-1:0] WriteAddr;
  logic [DW-1:0] WriteData;

  modport master (
    output pipe_we, pipe_addr, pipe_data,
    output lu_valid, lu_addr, lu_data,
    output issue_en, issue_addr,
    input  lu_ready, busy,
    input  WriteEn, WriteAddr, WriteData
  );

  modport slave (
    input  pipe_we, pipe_addr, pipe_data,
    input  lu_valid, lu_addr, lu_data,
    input  issue_en, issue_addr,
    output lu_ready, busy,
    output WriteEn, WriteAddr, WriteData
  );
endinterface

// File: rtl/regfile_writeback_arbiter.sv
// Register-file write-back arbiter.
// Merges single-cycle pipeline results (highest priority) and long-latency
// results (buffered in a DEPTH-entry FIFO) onto the register file's single
// write port, and keeps a pending-register scoreboard for decode stalls.
// Ports:
//   clk  : clock, all state updates on the rising edge
//   rst  : asynchronous active-high reset
//   bus  : slave side of regfile_writeback_arbiter_if
//          in : pipe_we/pipe_addr/pipe_data, lu_valid/lu_addr/lu_data,
//               issue_en/issue_addr
//          out: lu_ready, busy[31:0], WriteEn/WriteAddr/WriteData (registered)
module regfile_writeback_arbiter #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  regfile_writeback_arbiter_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  typedef logic [PW-1:0] ptr_t;
  typedef logic [PW:0]   cnt_t;

  logic [AW-1:0] fifoAddr [DEPTH];
  logic [DW-1:0] fifoData [DEPTH];
  ptr_t          rdPtr;
  ptr_t          wrPtr;
  cnt_t          count;

  logic          pipeReq;
  logic          luAccept;
  logic          push;
  logic          pop;
  logic [31:0]   setMask;
  logic [31:0]   clrMask;

  // Ready comes from the registered count only, so a pop in the same cycle
  // never opens a slot for a push while full.
  assign bus.lu_ready = (count != cnt_t'(DEPTH));

  // Writes to register 0 are no-ops: a pipeline write to r0 frees the slot
  // for the FIFO, and a long-latency result for r0 is accepted and dropped.
  assign pipeReq  = bus.pipe_we && (bus.pipe_addr != '0);
  assign luAccept = bus.lu_valid && bus.lu_ready;
  assign push     = luAccept && (bus.lu_addr != '0);
  assign pop      = !pipeReq && (count != '0);

  always_comb begin
    setMask = '0;
    clrMask = '0;
    if (bus.issue_en && (bus.issue_addr != '0)) begin
      setMask[bus.issue_addr] = 1'b1;
    end
    if (pop) begin
      clrMask[fifoAddr[rdPtr]] = 1'b1;
    end
  end

  // FIFO control and scoreboard
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdPtr    <= '0;
      wrPtr    <= '0;
      count    <= '0;
      bus.busy <= '0;
    end else begin
      if (push) begin
        wrPtr <= wrPtr + ptr_t'(1);
      end
      if (pop) begin
        rdPtr <= rdPtr + ptr_t'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + cnt_t'(1);
        2'b01:   count <= count - cnt_t'(1);
        default: count <= count;
      endcase
      bus.busy <= (bus.busy | setMask) & ~clrMask & ~32'd1;
    end
  end

  // FIFO storage: data only, validity is tracked by the pointers and count
  always_ff @(posedge clk) begin
    if (push) begin
      fifoAddr[wrPtr] <= bus.lu_addr;
      fifoData[wrPtr] <= bus.lu_data;
    end
  end

  // Write-port register stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.WriteEn   <= 1'b0;
      bus.WriteAddr <= '0;
      bus.WriteData <= '0;
    end else if (pipeReq) begin
      bus.WriteEn   <= 1'b1;
      bus.WriteAddr <= bus.pipe_addr;
      bus.WriteData <= bus.pipe_data;
    end else if (pop) begin
      bus.WriteEn   <= 1'b1;
      bus.WriteAddr <= fifoAddr[rdPtr];
      bus.WriteData <= fifoData[rdPtr];
    end else begin
      bus.WriteEn   <= 1'b0;
    end
  end
endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Bench for regfile_writeback_arbiter: directed scenarios followed by a
// randomized phase, all compared each cycle against a queue-based model of
// the write-back rules (pipeline first, then oldest buffered result).
module tb_regfile_writeback_arbiter;
  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int DW    = 32;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_writeback_arbiter_if #(.AW(AW), .DW(DW)) bus();

  regfile_writeback_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int nAssert = 0;
  int nFail   = 0;

  // Model state
  ent_t          q[$];      // results accepted but not yet written
  ent_t          luSrc[$];  // results waiting to be offered by the LU
  logic [31:0]   mBusy;
  logic          mWe;
  logic [AW-1:0] mWa;
  logic [DW-1:0] mWd;
  logic          autoResp = 1'b0;
  logic          throttle = 1'b0;
  logic          held     = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clearIn();
    bus.pipe_we    = 1'b0;
    bus.pipe_addr  = '0;
    bus.pipe_data  = '0;
    bus.issue_en   = 1'b0;
    bus.issue_addr = '0;
    bus.lu_valid   = 1'b0;
    bus.lu_addr    = '0;
    bus.lu_data    = '0;
  endtask

  task automatic modelReset();
    q.delete();
    luSrc.delete();
    mBusy = '0;
    mWe   = 1'b0;
    mWa   = '0;
    mWd   = '0;
    held  = 1'b0;
  endtask

  task automatic addLu(input logic [AW-1:0] a, input logic [DW-1:0] d);
    ent_t e;
    e.a = a;
    e.d = d;
    luSrc.push_back(e);
  endtask

  // One clock cycle: offer the LU head, check pre-edge outputs, advance the
  // model over the edge, then check the registered outputs.
  task automatic step();
    logic rdy;
    logic pReq;
    logic acc;
    ent_t e;
    if (luSrc.size() > 0 && (held || !throttle || $urandom_range(0, 2) != 0)) begin
      bus.lu_valid = 1'b1;
      bus.lu_addr  = luSrc[0].a;
      bus.lu_data  = luSrc[0].d;
    end else begin
      bus.lu_valid = 1'b0;
      bus.lu_addr  = '0;
      bus.lu_data  = '0;
    end
    rdy = (q.size() != DEPTH);
    chk("lu_ready", 64'(bus.lu_ready), 64'(rdy));
    if (bus.pipe_we)
      chk("proto_pipe_busy", 64'(bus.busy[bus.pipe_addr]), 64'(0));
    if (bus.issue_en)
      chk("proto_issue_busy", 64'(bus.busy[bus.issue_addr]), 64'(0));
    if (bus.lu_valid && bus.lu_addr != '0)
      chk("proto_lu_busy", 64'(bus.busy[bus.lu_addr]), 64'(1));
    acc  = bus.lu_valid && rdy;
    pReq = bus.pipe_we && (bus.pipe_addr != '0);
    @(posedge clk);
    #1;
    if (pReq) begin
      mWe = 1'b1;
      mWa = bus.pipe_addr;
      mWd = bus.pipe_data;
    end else if (q.size() > 0) begin
      e   = q.pop_front();
      mWe = 1'b1;
      mWa = e.a;
      mWd = e.d;
      mBusy[e.a] = 1'b0;
    end else begin
      mWe = 1'b0;
    end
    if (acc) begin
      e = luSrc.pop_front();
      if (e.a != '0) q.push_back(e);
    end
    held = bus.lu_valid && !acc;
    if (bus.issue_en && bus.issue_addr != '0) begin
      mBusy[bus.issue_addr] = 1'b1;
      if (autoResp) addLu(bus.issue_addr, $urandom);
    end
    chk("WriteEn",   64'(bus.WriteEn),   64'(mWe));
    chk("WriteAddr", 64'(bus.WriteAddr), 64'(mWa));
    chk("WriteData", 64'(bus.WriteData), 64'(mWd));
    chk("busy",      64'(bus.busy),      64'(mBusy));
  endtask

  task automatic idle(input int n);
    bus.pipe_we  = 1'b0;
    bus.issue_en = 1'b0;
    repeat (n) step();
  endtask

  function automatic logic [AW-1:0] pickFree();
    logic [AW-1:0] a;
    for (int t = 0; t < 32; t++) begin
      a = AW'($urandom_range(0, 31));
      if (!mBusy[a]) return a;
    end
    return '0;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [AW-1:0] pa;
    logic [AW-1:0] ia;
    int guard;

    // Reset and idle
    rst = 1'b1;
    clearIn();
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(3);
    chk("reset_lu_ready", 64'(bus.lu_ready), 64'(1));

    // Single pipeline write
    bus.pipe_we   = 1'b1;
    bus.pipe_addr = 5'd5;
    bus.pipe_data = 32'hDEADBEEF;
    step();
    chk("pipe_addr5", 64'(bus.WriteAddr), 64'(5));
    chk("pipe_data5", 64'(bus.WriteData), 64'(32'hDEADBEEF));
    idle(1);
    chk("pipe_we_drop", 64'(bus.WriteEn), 64'(0));

    // Long-latency result for r7, three cycles after issue
    bus.issue_en   = 1'b1;
    bus.issue_addr = 5'd7;
    step();
    bus.issue_en = 1'b0;
    idle(3);
    chk("busy7_pending", 64'(bus.busy[7]), 64'(1));
    addLu(5'd7, 32'h12345678);
    step();
    chk("lu7_not_bypassed", 64'(bus.WriteEn), 64'(0));
    step();
    chk("lu7_we",   64'(bus.WriteEn),   64'(1));
    chk("lu7_addr", 64'(bus.WriteAddr), 64'(7));
    chk("busy7_cleared", 64'(bus.busy[7]), 64'(0));
    idle(1);

    // Fill the FIFO behind continuous pipeline traffic, then drain
    for (int r = 10; r <= 14; r++) begin
      bus.issue_en   = 1'b1;
      bus.issue_addr = AW'(r);
      step();
    end
    bus.issue_en = 1'b0;
    for (int r = 10; r <= 14; r++) addLu(AW'(r), 32'hA000_0000 + 32'(r));
    for (int i = 1; i <= 8; i++) begin
      bus.pipe_we   = 1'b1;
      bus.pipe_addr = AW'(i);
      bus.pipe_data = $urandom;
      step();
    end
    chk("full_ready_low", 64'(bus.lu_ready), 64'(0));
    bus.pipe_we = 1'b0;
    step();
    chk("drain_first", 64'(bus.WriteAddr), 64'(10));
    chk("ready_after_pop", 64'(bus.lu_ready), 64'(1));
    idle(6);

    // Six results through a four-entry FIFO (pointer wrap)
    for (int r = 15; r <= 20; r++) begin
      bus.issue_en   = 1'b1;
      bus.issue_addr = AW'(r);
      step();
    end
    bus.issue_en = 1'b0;
    for (int r = 15; r <= 20; r++) addLu(AW'(r), $urandom);
    idle(10);

    // Randomized traffic
    throttle = 1'b1;
    autoResp = 1'b1;
    for (int c = 0; c < 300; c++) begin
      pa = pickFree();
      bus.pipe_we   = ($urandom_range(0, 1) == 1);
      bus.pipe_addr = pa;
      bus.pipe_data = $urandom;
      ia = pickFree();
      bus.issue_en   = ($urandom_range(0, 3) == 0) && (ia != '0) && (ia != pa);
      bus.issue_addr = ia;
      step();
    end
    bus.pipe_we  = 1'b0;
    bus.issue_en = 1'b0;
    guard = 0;
    while ((luSrc.size() > 0 || q.size() > 0) && guard < 100) begin
      step();
      guard++;
    end
    chk("random_drained", 64'(guard < 100), 64'(1));
    idle(2);
    throttle = 1'b0;
    autoResp = 1'b0;

    // Register 0 handling: pipe r0 slot lets the FIFO drain, lu r0 dropped
    bus.issue_en   = 1'b1;
    bus.issue_addr = 5'd20;
    step();
    bus.issue_en = 1'b0;
    addLu(5'd20, 32'h0000AAAA);
    bus.pipe_we   = 1'b1;
    bus.pipe_addr = 5'd3;
    bus.pipe_data = 32'h33333333;
    step();
    addLu(5'd0, 32'h55555555);
    bus.pipe_addr = 5'd0;
    bus.pipe_data = 32'h0BADBAD0;
    step();
    chk("r0_slot_drain_addr", 64'(bus.WriteAddr), 64'(20));
    bus.pipe_we = 1'b0;
    step();
    chk("r0_no_write", 64'(bus.WriteEn), 64'(0));
    chk("busy0_zero", 64'(bus.busy[0]), 64'(0));

    // Reset with three results queued
    for (int r = 21; r <= 23; r++) begin
      bus.issue_en   = 1'b1;
      bus.issue_addr = AW'(r);
      step();
    end
    bus.issue_en = 1'b0;
    for (int r = 21; r <= 23; r++) addLu(AW'(r), $urandom);
    bus.pipe_we   = 1'b1;
    bus.pipe_addr = 5'd1;
    bus.pipe_data = 32'h11111111;
    repeat (3) step();
    chk("queued_three_ready", 64'(bus.lu_ready), 64'(1));
    chk("queued_busy", 64'(bus.busy[23:21]), 64'(3'b111));
    #2;
    rst = 1'b1;
    #1;
    modelReset();
    clearIn();
    chk("async_rst_we",    64'(bus.WriteEn),   64'(0));
    chk("async_rst_busy",  64'(bus.busy),      64'(0));
    chk("async_rst_ready", 64'(bus.lu_ready),  64'(1));
    chk("async_rst_addr",  64'(bus.WriteAddr), 64'(0));
    chk("async_rst_data",  64'(bus.WriteData), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(4);
    chk("post_rst_no_write", 64'(bus.WriteEn), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end
endmodule

// File: doc/regfile_writeback_arbiter.md
Name: regfile_writeback_arbiter

Overview:
- Write-back stage directly upstream of the 32x32 register file.
- Merges two result sources onto the register file's single write port: the main pipeline (single-cycle, highest priority) and a long-latency unit (multiply/divide) with a valid/ready handshake.
- Long-latency results are buffered in a small FIFO and drained into free write slots.
- Keeps a 32-bit pending-register scoreboard so the decode stage can stall RAW/WAW hazards.

Parameters:
- DEPTH, 4, long-latency result FIFO entries (power of two, >=2)
- AW, 5, register address width
- DW, 32, data width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- pipe_we  in  1  main pipeline write request this cycle
- pipe_addr  in  AW  main pipeline destination register
- pipe_data  in  DW  main pipeline result
- lu_valid  in  1  long-latency unit result valid
- lu_addr  in  AW  long-latency destination register
- lu_data  in  DW  long-latency result
- lu_ready  out  1  arbiter can accept a long-latency result
- issue_en  in  1  long-latency op issued this cycle (marks destination pending)
- issue_addr  in  AW  destination of the issued op
- busy  out  32  pending bitmap, bit i = register i awaiting long-latency result
- WriteEn  out  1  register file write enable (registered)
- WriteAddr  out  AW  register file write address (registered)
- WriteData  out  DW  register file write data (registered)

Behaviour:
- Reset (async, immediate):
  - FIFO empty (count=0, rd/wr pointers 0), busy=0.
  - WriteEn=0, WriteAddr=0, WriteData=0.
  - lu_ready=1 once count=0; inputs are ignored while rst=1.
- lu_ready = (count != DEPTH), derived from registered count only.
  - A pop in the same cycle does not raise lu_ready when full.
- Long-latency accept on lu_valid && lu_ready at a rising edge:
  - lu_addr != 0: push {lu_addr, lu_data}.
  - lu_addr == 0: accept and discard, no push.
- Per-edge arbitration for the write port:
  - pipe_we && pipe_addr != 0: WriteEn<=1, WriteAddr<=pipe_addr, WriteData<=pipe_data; FIFO does not pop.
  - else if count > 0: pop FIFO head into WriteEn/WriteAddr/WriteData (WriteEn<=1).
  - else: WriteEn<=0; WriteAddr/WriteData hold their previous values.
  - pipe_we with pipe_addr == 0 counts as no request, so the FIFO may drain that cycle.
- Latency:
  - Pipeline result: WriteEn high 1 cycle after the request; register file updated on the following edge.
  - Long-latency result: earliest WriteEn 1 cycle after acceptance (no bypass around the FIFO); later while the pipeline holds the port.
- Simultaneous push and pop: count unchanged, pointers both advance modulo DEPTH. Pointer wrap-around is mandatory.
- FIFO order is strict: results are written in acceptance order.
- Scoreboard:
  - issue_en && issue_addr != 0 sets busy[issue_addr].
  - A FIFO pop with address a clears busy[a] at the same edge it loads WriteEn.
  - busy[0] is always 0.
- Protocol rules (upstream-guaranteed; bench asserts them):
  - No pipe_we to a register with busy=1.
  - No issue_en to a register with busy=1.
  - No lu_valid for a register with busy=0.
  - Consequence: set and clear of the same bit never coincide.
- lu_valid held with lu_ready=0: lu_addr/lu_data must remain stable; no loss, no duplication.
- Reset mid-operation: all queued results and busy bits are discarded immediately; WriteEn drops asynchronously.

Test Plan:
- Reset, then idle 3 cycles -> WriteEn=0, busy=0, lu_ready=1, WriteAddr=0, WriteData=0.
- pipe_we=1, addr=5, data=0xDEADBEEF for 1 cycle -> next cycle WriteEn=1, WriteAddr=5, WriteData=0xDEADBEEF; following cycle WriteEn=0.
- issue_en addr=7; 3 cycles later lu result addr=7, data=0x12345678 with no pipeline traffic:
  - busy[7]=1 from issue until the pop edge.
  - WriteEn=1, WriteAddr=7 one cycle after acceptance, then busy[7]=0.
- Continuous pipe_we (addr 1..8) while lu pushes 4 results (regs 10..13):
  - FIFO fills and lu_ready=0 on a 5th valid.
  - After pipe_we drops, writes drain as 10,11,12,13 on consecutive cycles.
  - lu_ready returns to 1 the cycle after the first pop.
- 6 pushes and 6 pops interleaved with DEPTH=4 (pointer wrap) -> output order equals input order, count never exceeds 4.
- Writes to register 0 via pipe and lu -> WriteEn never asserts for address 0, a queued FIFO entry drains in that pipe slot, busy[0]=0. Then assert rst with 3 entries queued -> WriteEn=0, busy=0, lu_ready=1 immediately, and no queued write appears after reset release.
